// File: rtl/apb_subsystem_pkg.sv
// Shared types and default sizing for the APB subsystem.
package apb_subsystem_pkg;

    localparam int DEF_ADD_WIDTH = 9;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_S1_WAIT   = 3;
    localparam int STRB_W        = DEF_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_mem_slave.sv
// APB memory slave with byte-lane write strobes and a fixed number of
// wait states per transfer.
module apb_mem_slave
    import apb_subsystem_pkg::*;
#(
    parameter int ADD_WIDTH = DEF_ADD_WIDTH - 1,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int WAIT      = 0
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADD_WIDTH-1:0] paddr,
    input  logic [WIDTH-1:0]     pwdata,
    input  logic [WIDTH/8-1:0]   pstrb,
    output logic [WIDTH-1:0]     prdata,
    output logic                 pready
);

    localparam int DEPTH = 1 << ADD_WIDTH;
    localparam int CNT_W = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_TC = CNT_W'(WAIT);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] wait_cnt;
    logic             access;
    logic             complete;

    assign access   = psel & penable;
    assign complete = access & pready;

    // pready rises once the wait counter reaches its terminal count; with
    // zero wait states the counter never moves and pready stays high.
    assign pready = (wait_cnt == WAIT_TC);
    assign prdata = mem[paddr];

    // Wait-state counter: advances on each stalled ACCESS cycle, clears on completion.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            wait_cnt <= '0;
        end else if (complete) begin
            wait_cnt <= '0;
        end else if (access) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Memory array: cleared on reset, byte-masked write on the completing ACCESS edge.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (complete && pwrite) begin
            for (int b = 0; b < WIDTH / 8; b++) begin
                if (pstrb[b]) begin
                    mem[paddr][8*b +: 8] <= pwdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/apb_subsystem.sv
// Request-driven APB master with two memory slaves on a shared bus.
// The address MSB selects the slave; reads return on Req_rdata.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | bus quiet, waiting for transfer
//   SETUP  | request captured, psel asserted, penable low (one cycle)
//   ACCESS | penable high, held until the selected slave gives pready
module apb_subsystem
    import apb_subsystem_pkg::*;
#(
    parameter int ADD_WIDTH = DEF_ADD_WIDTH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int S1_WAIT   = DEF_S1_WAIT
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 transfer,
    input  logic                 Req_read_write,
    input  logic [WIDTH/8-1:0]   Req_pstrb,
    input  logic [ADD_WIDTH-1:0] Req_addr,
    input  logic [WIDTH-1:0]     Req_wdata,
    output logic [WIDTH-1:0]     Req_rdata
);

    apb_state_t state;
    apb_state_t next_state;
    logic       capture;

    logic [ADD_WIDTH-1:0] paddr;
    logic                 pwrite;
    logic [WIDTH-1:0]     pwdata;
    logic [WIDTH/8-1:0]   pstrb;
    logic                 psel0;
    logic                 psel1;
    logic                 penable;
    logic                 pready;
    logic [WIDTH-1:0]     prdata;

    logic                 pready0;
    logic                 pready1;
    logic [WIDTH-1:0]     prdata0;
    logic [WIDTH-1:0]     prdata1;
    logic                 slv_sel;

    assign slv_sel = paddr[ADD_WIDTH-1];

    // Master state register.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, request capture strobe and APB control outputs.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        psel0      = 1'b0;
        psel1      = 1'b0;
        penable    = 1'b0;
        case (state)
            IDLE: begin
                if (transfer) begin
                    capture    = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                psel0      = ~slv_sel;
                psel1      = slv_sel;
                next_state = ACCESS;
            end
            ACCESS: begin
                psel0   = ~slv_sel;
                psel1   = slv_sel;
                penable = 1'b1;
                if (pready) begin
                    if (transfer) begin
                        capture    = 1'b1;
                        next_state = SETUP;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bus registers: loaded only at a capture point so requester changes
    // mid-transfer cannot disturb the bus. Reads never carry a strobe.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
        end else if (capture) begin
            paddr  <= Req_addr;
            pwrite <= Req_read_write;
            pwdata <= Req_wdata;
            pstrb  <= Req_read_write ? Req_pstrb : '0;
        end
    end

    assign pready = slv_sel ? pready1 : pready0;
    assign prdata = slv_sel ? prdata1 : prdata0;

    // Read-return register: updated on the completing edge of a read only.
    always_ff @(posedge pclk) begin
        if (presetn) begin
            Req_rdata <= '0;
        end else if (penable && pready && !pwrite) begin
            Req_rdata <= prdata;
        end
    end

    apb_mem_slave #(
        .ADD_WIDTH (ADD_WIDTH - 1),
        .WIDTH     (WIDTH),
        .WAIT      (0)
    ) u_slave0 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel0),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr[ADD_WIDTH-2:0]),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata0),
        .pready  (pready0)
    );

    apb_mem_slave #(
        .ADD_WIDTH (ADD_WIDTH - 1),
        .WIDTH     (WIDTH),
        .WAIT      (S1_WAIT)
    ) u_slave1 (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel1),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr[ADD_WIDTH-2:0]),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata1),
        .pready  (pready1)
    );

endmodule

// File: tb/tb_apb_subsystem.sv
// Self-checking bench for apb_subsystem against a word-array memory model.
module tb_apb_subsystem;
    import apb_subsystem_pkg::*;

    logic        pclk;
    logic        presetn;
    logic        transfer;
    logic        Req_read_write;
    logic [3:0]  Req_pstrb;
    logic [8:0]  Req_addr;
    logic [31:0] Req_wdata;
    logic [31:0] Req_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [2][256];

    apb_subsystem dut (
        .pclk           (pclk),
        .presetn        (presetn),
        .transfer       (transfer),
        .Req_read_write (Req_read_write),
        .Req_pstrb      (Req_pstrb),
        .Req_addr       (Req_addr),
        .Req_wdata      (Req_wdata),
        .Req_rdata      (Req_rdata)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 256; i++)
                mem_m[s][i] = 32'h0;
    endfunction

    function automatic void model_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) mem_m[a[8]][a[7:0]][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic logic [31:0] model_read(input logic [8:0] a);
        return mem_m[a[8]][a[7:0]];
    endfunction

    function automatic int exp_cycles(input logic [8:0] a);
        return a[8] ? 2 + DEF_S1_WAIT : 2;
    endfunction

    // Runs one isolated transfer; reports psel cycles, stalled ACCESS cycles
    // and Req_rdata one cycle after completion.
    task automatic xfer(input logic wr, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int cycles, output int waits, output logic [31:0] rdata);
        logic done;
        @(negedge pclk);
        transfer = 1'b1; Req_read_write = wr; Req_addr = a; Req_wdata = d; Req_pstrb = s;
        @(posedge pclk);
        @(negedge pclk);
        transfer = 1'b0;
        Req_wdata = $urandom;
        cycles = 0; waits = 0; done = 1'b0;
        for (int i = 0; i < 32 && !done; i++) begin
            if (dut.psel0 || dut.psel1) cycles++;
            if (dut.penable && !dut.pready) waits++;
            if (dut.penable && dut.pready) done = 1'b1;
            @(posedge pclk);
            @(negedge pclk);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL xfer_timeout addr=%h: no completion within 32 cycles", a);
        end
        rdata = Req_rdata;
        if (wr) model_write(a, d, s);
    endtask

    task automatic test_reset();
        presetn = 1'b1;
        transfer = 1'b0; Req_read_write = 1'b0; Req_pstrb = 4'h0; Req_addr = '0; Req_wdata = '0;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        model_clear();
        checks++;
        if (Req_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h want %h", Req_rdata, 32'h0);
        end
        checks++;
        if ({dut.psel0, dut.psel1, dut.penable} !== 3'b000) begin
            failures++;
            $display("FAIL reset_bus: got psel0/psel1/penable=%b want 000", {dut.psel0, dut.psel1, dut.penable});
        end
        presetn = 1'b0;
    endtask

    task automatic test_write_read(input string name, input logic [8:0] a, input logic [31:0] d, input logic [3:0] s);
        int c, w;
        logic [31:0] r;
        xfer(1'b1, a, d, s, c, w, r);
        checks++;
        if (c !== exp_cycles(a) || w !== exp_cycles(a) - 2) begin
            failures++;
            $display("FAIL %s_wr_timing: got cycles=%0d waits=%0d want cycles=%0d waits=%0d", name, c, w, exp_cycles(a), exp_cycles(a) - 2);
        end
        xfer(1'b0, a, $urandom, 4'hf, c, w, r);
        checks++;
        if (c !== exp_cycles(a) || w !== exp_cycles(a) - 2) begin
            failures++;
            $display("FAIL %s_rd_timing: got cycles=%0d waits=%0d want cycles=%0d waits=%0d", name, c, w, exp_cycles(a), exp_cycles(a) - 2);
        end
        checks++;
        if (r !== model_read(a)) begin
            failures++;
            $display("FAIL %s_rdata: got %h want %h", name, r, model_read(a));
        end
    endtask

    task automatic test_full_rw();
        test_write_read("full_s0", 9'h003, 32'h11223344, 4'b1111);
    endtask

    task automatic test_strobe();
        test_write_read("strb_1110", 9'h003, 32'hAABBCCDD, 4'b1110);
        test_write_read("strb_0111", 9'h003, 32'h55667788, 4'b0111);
        test_write_read("strb_0000", 9'h003, 32'hFFFFFFFF, 4'b0000);
    endtask

    task automatic test_slave1_wait();
        test_write_read("s1_wait", 9'h100, 32'hDEADBEEF, 4'b1111);
    endtask

    task automatic test_isolation();
        int c, w;
        logic [31:0] r;
        xfer(1'b1, 9'h005, 32'h12345678, 4'hf, c, w, r);
        xfer(1'b1, 9'h105, 32'h87654321, 4'hf, c, w, r);
        xfer(1'b0, 9'h005, 32'h0, 4'hf, c, w, r);
        checks++;
        if (r !== model_read(9'h005)) begin
            failures++;
            $display("FAIL iso_s0: got %h want %h", r, model_read(9'h005));
        end
        xfer(1'b0, 9'h105, 32'h0, 4'hf, c, w, r);
        checks++;
        if (r !== model_read(9'h105)) begin
            failures++;
            $display("FAIL iso_s1: got %h want %h", r, model_read(9'h105));
        end
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        int c, w;
        logic [31:0] r;
        @(negedge pclk);
        transfer = 1'b1; Req_read_write = 1'b1; Req_pstrb = 4'hf; Req_addr = 9'h000; Req_wdata = 32'h0;
        @(posedge pclk);
        for (int k = 0; k < 3; k++) begin
            @(negedge pclk);
            if (k < 2) begin
                Req_addr = 9'(k + 1); Req_wdata = 32'(k + 1);
            end else begin
                transfer = 1'b0;
            end
            if (!(dut.psel0 && !dut.penable)) gaps++;
            @(posedge pclk);
            @(negedge pclk);
            if (!(dut.psel0 && dut.penable && dut.pready)) gaps++;
            model_write(9'(k), 32'(k), 4'hf);
            @(posedge pclk);
        end
        checks++;
        if (gaps !== 0) begin
            failures++;
            $display("FAIL b2b_no_idle: got %0d off-pattern cycles want 0", gaps);
        end
        @(negedge pclk);
        checks++;
        if ({dut.psel0, dut.psel1, dut.penable} !== 3'b000) begin
            failures++;
            $display("FAIL b2b_idle: got psel0/psel1/penable=%b want 000", {dut.psel0, dut.psel1, dut.penable});
        end
        for (int k = 0; k < 3; k++) begin
            xfer(1'b0, 9'(k), 32'h0, 4'hf, c, w, r);
            checks++;
            if (r !== model_read(9'(k))) begin
                failures++;
                $display("FAIL b2b_read%0d: got %h want %h", k, r, model_read(9'(k)));
            end
        end
        repeat (3) @(posedge pclk);
        xfer(1'b1, 9'h006, 32'hCAFEF00D, 4'hf, c, w, r);
        checks++;
        if (r !== model_read(9'h002)) begin
            failures++;
            $display("FAIL b2b_rdata_hold: got %h want %h", r, model_read(9'h002));
        end
    endtask

    task automatic test_random();
        int c, w;
        logic [31:0] r;
        logic        s, wr;
        logic [8:0]  a;
        for (int n = 0; n < 40; n++) begin
            s  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = {s, 8'($urandom_range(0, 7))};
            xfer(wr, a, $urandom, 4'($urandom), c, w, r);
            checks++;
            if (c !== exp_cycles(a)) begin
                failures++;
                $display("FAIL rnd%0d_cycles addr=%h: got %0d want %0d", n, a, c, exp_cycles(a));
            end
            if (!wr) begin
                checks++;
                if (r !== model_read(a)) begin
                    failures++;
                    $display("FAIL rnd%0d_rdata addr=%h: got %h want %h", n, a, r, model_read(a));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int c, w;
        logic [31:0] r;
        xfer(1'b0, 9'h100, 32'h0, 4'hf, c, w, r);
        @(negedge pclk);
        transfer = 1'b1; Req_read_write = 1'b1; Req_addr = 9'h101; Req_wdata = 32'hA5A5A5A5; Req_pstrb = 4'hf;
        @(posedge pclk);
        @(negedge pclk);
        transfer = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        checks++;
        if (!(dut.psel1 && dut.penable)) begin
            failures++;
            $display("FAIL rstmid_in_access: got psel1=%b penable=%b want 1 1", dut.psel1, dut.penable);
        end
        presetn = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        presetn = 1'b0;
        model_clear();
        checks++;
        if ({dut.psel0, dut.psel1, dut.penable} !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_idle: got psel0/psel1/penable=%b want 000", {dut.psel0, dut.psel1, dut.penable});
        end
        checks++;
        if (Req_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_rdata: got %h want %h", Req_rdata, 32'h0);
        end
        xfer(1'b0, 9'h101, 32'h0, 4'hf, c, w, r);
        checks++;
        if (r !== model_read(9'h101)) begin
            failures++;
            $display("FAIL rstmid_read101: got %h want %h", r, model_read(9'h101));
        end
        xfer(1'b0, 9'h003, 32'h0, 4'hf, c, w, r);
        checks++;
        if (r !== model_read(9'h003)) begin
            failures++;
            $display("FAIL rstmid_read003: got %h want %h", r, model_read(9'h003));
        end
    endtask

    initial begin
        test_reset();
        test_full_rw();
        test_strobe();
        test_slave1_wait();
        test_isolation();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_subsystem.md
Name: apb_subsystem

Overview:
- Self-contained APB subsystem: a request-driven APB master FSM plus two APB memory slaves on one shared bus.
- A simple request port (transfer, read/write, strobe, address, write data) is converted into APB SETUP/ACCESS cycles.
- Address MSB selects the slave. Read data returns to the requester on Req_rdata.
- Serves as the top level of the APB block and as a standalone verification target.

Parameters:
- ADD_WIDTH, 9, request address width. Bit ADD_WIDTH-1 selects the slave; the low ADD_WIDTH-1 bits are the word index.
- WIDTH, 32, data width in bits. Must be a multiple of 8; the strobe is WIDTH/8 bits.
- S1_WAIT, 3, wait states inserted by slave 1 per transfer. Slave 0 has 0 wait states.

Ports:
- pclk  in  1  clock; all state changes on the rising edge.
- presetn  in  1  synchronous, active-high reset (1 = reset).
- transfer  in  1  request valid; held high for back-to-back transfers.
- Req_read_write  in  1  1 = write, 0 = read.
- Req_pstrb  in  WIDTH/8  byte write enables, one bit per byte lane.
- Req_addr  in  ADD_WIDTH  word address.
- Req_wdata  in  WIDTH  write data.
- Req_rdata  out  WIDTH  data returned by the most recently completed read.

Behaviour:
- Internal APB bus signals:
  - paddr, pwrite, pwdata, pstrb, psel0/psel1, penable.
  - pready and prdata are muxed from the selected slave.
- Reset (presetn=1 at a clock edge):
  - FSM goes to IDLE; psel*, penable = 0; bus registers = 0.
  - Req_rdata = 0; wait counters = 0; both slave memories cleared to 0.
- Master FSM states and transitions:
  - IDLE: if transfer=1, latch Req_* into the bus registers and go to SETUP. Otherwise stay.
  - SETUP: one cycle; psel[Req_addr[ADD_WIDTH-1]]=1, penable=0. Always go to ACCESS.
  - ACCESS: penable=1. If pready=0, stay and hold all bus signals stable.
  - ACCESS with pready=1, transfer=1: latch the new Req_* and go to SETUP (no IDLE gap).
  - ACCESS with pready=1, transfer=0: go to IDLE.
- Request capture:
  - Requests are sampled only when entering SETUP.
  - Requester changes mid-transfer are ignored until the next capture point.
- pstrb: driven from Req_pstrb on writes; forced to 0 on reads.
- Slave memory:
  - Each slave holds 2^(ADD_WIDTH-1) words of WIDTH bits, indexed by paddr[ADD_WIDTH-2:0].
  - Write occurs on the completing ACCESS edge (psel & penable & pready & pwrite). Byte lane i is updated only if pstrb[i]=1.
  - pstrb = 0 on a write: transfer completes normally, memory unchanged.
- Slave pready:
  - Slave 0: pready=1 throughout ACCESS.
  - Slave 1: counts S1_WAIT ACCESS cycles with pready=0, then asserts pready=1 for one cycle. The counter resets at completion.
- Transfer length:
  - Slave 0 transfer = 2 cycles.
  - Slave 1 transfer = 2+S1_WAIT cycles (5 at default).
- Read data:
  - prdata = mem[index], valid during ACCESS.
  - Req_rdata is registered from prdata on the completing edge of a read, i.e. visible one cycle after the last ACCESS cycle.
  - Req_rdata holds its value through writes and idle cycles.
- No pslverr: every address maps to a slave.
- Reset mid-transfer: the transfer is abandoned with no memory write and no Req_rdata update; FSM returns to IDLE next cycle.

Decomposition:
- Shared package holds:
  - FSM state enum {IDLE, SETUP, ACCESS};
  - default ADD_WIDTH, WIDTH, S1_WAIT constants;
  - STRB_W = WIDTH/8.
- One sub-module, apb_mem_slave (params ADD_WIDTH-1, WIDTH, WAIT), instantiated twice with WAIT=0 and WAIT=S1_WAIT.
- Master FSM, psel decode and prdata/pready mux stay in the top.

Test Plan:
- Full write then read, slave 0:
  - Write 0x003 = 0x11223344, pstrb 1111; then read 0x003.
  - Required: Req_rdata = 0x11223344; each transfer is 2 cycles.
- Strobe masking, slave 0 (after the full write above):
  - Write 0x003 = 0xAABBCCDD, pstrb 1110 -> read gives 0xAABBCC44.
  - Then pstrb 0111 with 0x55667788 -> read gives 0xAA667788.
  - Then pstrb 0000 -> read still gives 0xAA667788.
- Slave 1 wait states:
  - Write 0x100 = 0xDEADBEEF, pstrb 1111; then read 0x100.
  - Required: pready low for 3 ACCESS cycles; each transfer is 5 cycles; Req_rdata = 0xDEADBEEF.
- Slave isolation:
  - Write 0x005 = 0x12345678 and 0x105 = 0x87654321.
  - Required: reads return each slave's own value; 0x105 is not visible at 0x005.
- Back-to-back:
  - Hold transfer=1 across three writes to 0x000–0x002, data 0x0, 0x1, 0x2.
  - Required: no IDLE between transfers; reads 0x000–0x002 return 0, 1, 2.
  - After transfer drops, FSM returns to IDLE and Req_rdata holds 0x2.
- Reset:
  - Assert presetn=1 during a slave-1 ACCESS write to 0x101.
  - Required: FSM in IDLE; Req_rdata = 0; a read of 0x101 returns 0.
